// File: rtl/delay_align_search_pkg.sv
// Shared types and default parameters for the delay-line alignment search.
package delay_align_search_pkg;

  localparam int unsigned SYM_W           = 2;
  localparam int unsigned TAP_W           = 4;
  localparam int unsigned DEF_NUM_TAPS    = 11;
  localparam int unsigned DEF_SETTLE_SYMS = 16;
  localparam int unsigned DEF_WINDOW      = 256;
  localparam int unsigned DEF_LOCK_THRESH = 8;
  localparam int unsigned DEF_CNT_W       = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_NEXT    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/delay_align_search_sym_err_counter.sv
// Window/error counter: counts qualified symbol strobes and reference/decision mismatches.
// err_nxt (count including the current strobe) exists only with DELAY_ALIGN_TRACK_EN.
module sym_err_counter
  import delay_align_search_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             sym_clk_en,
  input  logic [SYM_W-1:0] ref_sym,
  input  logic [SYM_W-1:0] rx_sym,
  output logic [CNT_W-1:0] err_cnt,
`ifdef DELAY_ALIGN_TRACK_EN
  output logic [CNT_W-1:0] err_nxt,
`endif
  output logic             done
);

  logic             hit;
  logic             mis;
  logic             win_last;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    hit       = en && sym_clk_en;
    mis       = (ref_sym != rx_sym);
    win_last  = (win_cnt_q == CNT_W'(WINDOW - 1));
    err_inc   = err_cnt_q + {{(CNT_W-1){1'b0}}, mis};
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      win_cnt_d = '0;
      err_cnt_d = '0;
    end else if (hit) begin
      win_cnt_d = win_cnt_q + CNT_W'(1);
      err_cnt_d = err_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // done fires on the WINDOW-th strobe itself so the FSM leaves with that compare already counted
  assign done    = hit && win_last;
  assign err_cnt = err_cnt_q;
`ifdef DELAY_ALIGN_TRACK_EN
  assign err_nxt = err_inc;
`endif

endmodule

// File: rtl/delay_align_search.sv
// Sweeps the delay-line tap select, measures symbol errors per tap and locks to the best tap.
// Optional post-lock tracking with automatic re-search: define DELAY_ALIGN_TRACK_EN.
module delay_align_search
  import delay_align_search_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = DEF_NUM_TAPS,
  parameter int unsigned SETTLE_SYMS = DEF_SETTLE_SYMS,
  parameter int unsigned WINDOW      = DEF_WINDOW,
  parameter int unsigned LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             start,
  input  logic [SYM_W-1:0] ref_sym,
  input  logic [SYM_W-1:0] rx_sym,
  output logic [TAP_W-1:0] delay_change,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] best_err
);

  localparam int unsigned SET_W = (SETTLE_SYMS > 1) ? $clog2(SETTLE_SYMS) : 1;

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [TAP_W-1:0]   delay_q, delay_d;
  logic [TAP_W-1:0]   best_tap_q, best_tap_d;
  logic [CNT_W-1:0]   best_err_q, best_err_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;
  logic               fail_q, fail_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               win_done;
  logic               restart;
  logic [CNT_W-1:0]   err_cnt;
`ifdef DELAY_ALIGN_TRACK_EN
  logic [CNT_W-1:0]   err_nxt;
`endif

  sym_err_counter #(
    .CNT_W  (CNT_W),
    .WINDOW (WINDOW)
  ) u_err_cnt (
    .clk        (sys_clk),
    .rst_n      (reset),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .sym_clk_en (sym_clk_en),
    .ref_sym    (ref_sym),
    .rx_sym     (rx_sym),
    .err_cnt    (err_cnt),
`ifdef DELAY_ALIGN_TRACK_EN
    .err_nxt    (err_nxt),
`endif
    .done       (win_done)
  );

  // Kept apart from the FSM block so win_done does not feed back into its own enable
`ifdef DELAY_ALIGN_TRACK_EN
  assign cnt_en = (state_q == ST_MEASURE) || ((state_q == ST_IDLE) && locked_q);
`else
  assign cnt_en = (state_q == ST_MEASURE);
`endif

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    delay_d    = delay_q;
    best_tap_d = best_tap_q;
    best_err_d = best_err_q;
    settle_d   = settle_q;
    busy_d     = busy_q;
    locked_d   = locked_q;
    fail_d     = fail_q;
    cnt_clr    = 1'b0;
    restart    = start;

    unique case (state_q)
      ST_IDLE: begin
`ifdef DELAY_ALIGN_TRACK_EN
        if (locked_q && win_done) begin
          if (err_nxt > CNT_W'(LOCK_THRESH)) begin
            restart = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end
`endif
      end
      ST_SETTLE: begin
        if (sym_clk_en) begin
          if (settle_q == SET_W'(SETTLE_SYMS - 1)) begin
            state_d = ST_MEASURE;
            cnt_clr = 1'b1;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
      end
      ST_MEASURE: begin
        if (win_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (err_cnt < best_err_q) begin
          best_err_d = err_cnt;
          best_tap_d = tap_q;
        end
        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = ST_DONE;
        end else begin
          tap_d    = tap_q + TAP_W'(1);
          delay_d  = tap_q + TAP_W'(1);
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        delay_d  = best_tap_q;
        busy_d   = 1'b0;
        locked_d = (best_err_q <= CNT_W'(LOCK_THRESH));
        fail_d   = (best_err_q > CNT_W'(LOCK_THRESH));
        cnt_clr  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied last so a (re)start overrides whatever the current state decided
    if (restart) begin
      state_d    = ST_SETTLE;
      tap_d      = '0;
      delay_d    = '0;
      best_tap_d = '0;
      best_err_d = '1;
      settle_d   = '0;
      busy_d     = 1'b1;
      locked_d   = 1'b0;
      fail_d     = 1'b0;
      cnt_clr    = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      delay_q    <= '0;
      best_tap_q <= '0;
      best_err_q <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      delay_q    <= delay_d;
      best_tap_q <= best_tap_d;
      best_err_q <= best_err_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign delay_change = delay_q;
  assign busy         = busy_q;
  assign locked       = locked_q;
  assign fail         = fail_q;
  assign best_err     = best_err_q;

endmodule

// File: doc/delay_align_search.md
Name: delay_align_search

Overview:
- Automatic symbol-alignment controller for the reference-symbol delay line.
- Sweeps the 4-bit tap select (delay_change) over all taps and counts mismatches between delayed reference symbols and received slicer decisions.
- Locks to the tap with the fewest errors.
- Sits beside the delay line in the error-measurement path and drives its tap-select input in place of manual switches.

Parameters:
- NUM_TAPS, 11, number of candidate taps (0..NUM_TAPS-1); must be <=16.
- SETTLE_SYMS, 16, symbols ignored after each tap change (delay-line/pipeline flush).
- WINDOW, 256, symbols compared per tap.
- LOCK_THRESH, 8, maximum error count in the best window for lock to be declared.
- CNT_W, 9, error/window counter width; must hold WINDOW.

Ports:
- sys_clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- sym_clk_en, input, 1, one-cycle symbol strobe; all symbol counting is qualified by it.
- start, input, 1, one-cycle pulse that (re)starts a search.
- ref_sym, input, 2, delayed reference symbol from the delay line (symb_a).
- rx_sym, input, 2, received slicer decision.
- delay_change, output, 4, tap select to the delay line.
- busy, output, 1, search in progress.
- locked, output, 1, search finished with min errors <= LOCK_THRESH.
- fail, output, 1, search finished with min errors > LOCK_THRESH.
- best_err, output, CNT_W, error count of the selected tap.

Behaviour:
- Reset (async, reset=0) forces: state IDLE, delay_change=0, busy=0, locked=0, fail=0, best_err=0, all counters 0. Reset mid-search aborts immediately; no partial result is kept.
- FSM states: IDLE, SETTLE, MEASURE, NEXT, DONE.
- IDLE: outputs hold. On start: tap=0, delay_change=0, best_err=all-ones, best_tap=0, busy=1, locked=0, fail=0, go to SETTLE.
- SETTLE: count SETTLE_SYMS sym_clk_en pulses; on the last one, go to MEASURE with err_cnt=0 and win_cnt=0.
- MEASURE: on each sym_clk_en, win_cnt+1, and err_cnt+1 if ref_sym != rx_sym. After the WINDOW-th strobe (that strobe's compare included), go to NEXT.
- NEXT: single cycle. If err_cnt < best_err (strict), then best_err=err_cnt and best_tap=tap; ties keep the lower tap. If tap==NUM_TAPS-1, go to DONE; otherwise tap+1, delay_change=tap+1, go to SETTLE.
- DONE: delay_change=best_tap, busy=0, locked=(best_err<=LOCK_THRESH), fail=!locked. Return to IDLE next cycle with outputs held.
- delay_change changes only in IDLE->SETTLE, NEXT and DONE; it is registered and glitch-free.
- Without sym_clk_en pulses, the FSM stalls in SETTLE/MEASURE indefinitely. sym_clk_en in the NEXT/DONE cycle is not counted.
- start while busy restarts the search from tap 0; start has priority over all other transitions.
- err_cnt cannot overflow: max value is WINDOW.

Optional Feature:
- Macro: DELAY_ALIGN_TRACK_EN.
- Defined: after lock, the block keeps monitoring the locked tap in consecutive WINDOW-symbol windows without a settle phase. If any window's err_cnt > LOCK_THRESH, locked drops to 0 and a full search restarts automatically, as if start were pulsed. busy stays 0 during monitoring.
- Undefined: no post-lock monitoring; outputs are static until the next start or reset.

Decomposition:
- Shared package: FSM state encoding constants, symbol width (2), tap-select width (4), and default NUM_TAPS/WINDOW/SETTLE_SYMS/LOCK_THRESH.
- One natural sub-module, sym_err_counter: gated window/error counter with clear, sym_clk_en qualify, done pulse, and err_cnt output.
- FSM and best-tap tracking stay in the top module.

Test Plan:
- Aligned at tap 4: rx_sym = ref stream delayed so that tap 4 matches exactly (random elsewhere); pulse start -> busy for 11*(16+256) strobes, then delay_change=4, best_err=0, locked=1.
- Noisy best tap: tap 7 has 5 injected errors per window, all others ~75% errors -> delay_change=7, best_err=5, locked=1.
- No alignment: rx_sym random -> fail=1, locked=0, best_err>8, delay_change=lowest-error tap.
- Tie: taps 2 and 6 both 0 errors -> delay_change=2.
- Restart and reset: start pulsed mid-MEASURE at tap 5 -> delay_change returns to 0 next cycle and the sweep restarts. reset=0 mid-search -> all outputs 0 immediately.
- DELAY_ALIGN_TRACK_EN: after lock at tap 4, shift the channel delay to tap 9 -> locked falls after one window, auto-search completes with delay_change=9, locked=1.
